mul_sequencer: RTL and testbench

Multi-cycle 64-bit unsigned shift-add multiplier that sequences the shared 64-bit datapath ALU. It provides MUL for the processor without a dedicated multiplier array: one ALU ADD per iteration while it owns the ALU. It sits beside the ALU. While Busy is high, the datapath ALU-input mux selects this block's ALU drive signals. The result is the low 64 bits of the product (LEGv8 MUL semantics).

---
 rtl/mul_seq_pkg.sv | 20 ++
 rtl/mul_seq_datapath.sv | 54 +++++
 rtl/mul_sequencer.sv | 103 ++++++++++
 tb/tb_mul_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the shift-add multiply sequencer.
// Build option MUL_EARLY_EXIT_EN is consumed by the datapath, not here.
package mul_seq_pkg;

    localparam int WIDTH = 64;
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

endpackage

// File: rtl/mul_seq_datapath.sv
// Accumulator / multiplicand / multiplier / iteration-count registers.
// MUL_EARLY_EXIT_EN: also flag the last iteration once no multiplier bits remain.
module mul_seq_datapath
    import mul_seq_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int CW = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] mula,
    input  logic [W-1:0] mulb,
    input  logic [W-1:0] aluw,
    output logic [W-1:0] p,
    output logic [W-1:0] m,
    output logic         q0,
    output logic         last
);

    logic [W-1:0]  q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p   <= '0;
            m   <= '0;
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            p   <= '0;
            m   <= mula;
            q   <= mulb;
            cnt <= '0;
        end else if (step) begin
            if (q[0])
                p <= aluw;
            m   <= m << 1;
            q   <= q >> 1;
            cnt <= cnt + 1'b1;
        end
    end

    assign q0 = q[0];

`ifdef MUL_EARLY_EXIT_EN
    // q[W-1:1] is the multiplier after this iteration's shift.
    assign last = (cnt == CW'(W - 1)) || (q[W-1:1] == '0);
`else
    assign last = (cnt == CW'(W - 1));
`endif

endmodule

// File: rtl/mul_sequencer.sv
// Shift-add 64-bit multiplier that borrows the datapath ALU for one ADD per iteration.
// Build option MUL_EARLY_EXIT_EN shortens runs for small multipliers.
module mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = mul_seq_pkg::WIDTH,
    parameter int CNT_W = mul_seq_pkg::CNT_W
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] MulA,
    input  logic [WIDTH-1:0] MulB,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Product,
    output logic [WIDTH-1:0] ALUBusA,
    output logic [WIDTH-1:0] ALUBusB,
    output logic [3:0]       ALUCtrl,
    input  logic [WIDTH-1:0] ALUBusW,
    input  logic             ALUZero
);

    state_t           state;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] m;
    logic             q0;
    logic             last;
    logic             unused;

    assign unused = ALUZero;

    assign load = (state == IDLE) && Start;
    assign step = (state == RUN);

    mul_seq_datapath #(
        .W  (WIDTH),
        .CW (CNT_W)
    ) u_dp (
        .clk  (CLK),
        .rst  (Reset),
        .load (load),
        .step (step),
        .mula (MulA),
        .mulb (MulB),
        .aluw (ALUBusW),
        .p    (p),
        .m    (m),
        .q0   (q0),
        .last (last)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            Ready   <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            ALUCtrl <= ALU_AND;
            Product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= RUN;
                        Ready   <= 1'b0;
                        Busy    <= 1'b1;
                        ALUCtrl <= ALU_ADD;
                    end
                end
                RUN: begin
                    if (last) begin
                        state   <= DONE;
                        Done    <= 1'b1;
                        ALUCtrl <= ALU_AND;
                        // capture P as it will be after this iteration's add
                        Product <= q0 ? ALUBusW : p;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    Ready <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    Ready   <= 1'b1;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                    ALUCtrl <= ALU_AND;
                end
            endcase
        end
    end

    assign ALUBusA = (state == RUN) ? p : '0;
    assign ALUBusB = (state == RUN) ? m : '0;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomised and directed checks of mul_sequencer against an arithmetic reference.
// Honours MUL_EARLY_EXIT_EN when computing expected run length.
module tb_mul_sequencer;
    import mul_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [63:0] MulA, MulB;
    logic        Ready, Busy, Done;
    logic [63:0] Product, ALUBusA, ALUBusB, ALUBusW;
    logic [3:0]  ALUCtrl;
    logic        ALUZero;

    int vectors = 0;
    int miscompares = 0;

    mul_sequencer dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Start   (Start),
        .MulA    (MulA),
        .MulB    (MulB),
        .Ready   (Ready),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product),
        .ALUBusA (ALUBusA),
        .ALUBusB (ALUBusB),
        .ALUCtrl (ALUCtrl),
        .ALUBusW (ALUBusW),
        .ALUZero (ALUZero)
    );

    always #5 CLK = ~CLK;

    // datapath ALU stand-in
    always_comb begin
        ALUBusW = '0;
        case (ALUCtrl)
            ALU_AND:   ALUBusW = ALUBusA & ALUBusB;
            ALU_ORR:   ALUBusW = ALUBusA | ALUBusB;
            ALU_ADD:   ALUBusW = ALUBusA + ALUBusB;
            ALU_SUB:   ALUBusW = ALUBusA - ALUBusB;
            ALU_PASSB: ALUBusW = ALUBusB;
            default:   ALUBusW = '0;
        endcase
    end
    assign ALUZero = (ALUBusW == '0);

    function automatic int exp_n(input logic [63:0] b);
        int n;
`ifdef MUL_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < 64; i++)
            if (b[i]) n = i + 1;
`else
        n = 64;
`endif
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at cycle 1 (just after the accept edge); leaves in cycle N+2.
    task automatic run_body(input logic [63:0] a, input logic [63:0] b, input string tag);
        int n;
        int c;
        logic [63:0] mask;
        n = exp_n(b);
        c = 1;
        while (Done !== 1'b1 && c < 150) begin
            mask = (c - 1 >= 64) ? '1 : ((64'd1 << (c - 1)) - 64'd1);
            chk({tag, "/busy"}, 64'(Busy), 64'd1);
            chk({tag, "/ctrl"}, 64'(ALUCtrl), 64'(ALU_ADD));
            chk({tag, "/busA"}, ALUBusA, a * (b & mask));
            chk({tag, "/busB"}, ALUBusB, a << (c - 1));
            @(posedge CLK); #1;
            c++;
        end
        if (Done !== 1'b1) begin
            vectors++;
            miscompares++;
            $error("FAIL %s/timeout observed=no_done expected=done_in_cycle_%0d", tag, n + 1);
        end else begin
            chk({tag, "/done_cycle"}, 64'(c), 64'(n + 1));
            chk({tag, "/product"}, Product, a * b);
            chk({tag, "/ready_in_done"}, 64'(Ready), 64'd0);
            chk({tag, "/ctrl_in_done"}, 64'(ALUCtrl), 64'(ALU_AND));
            @(posedge CLK); #1;
            chk({tag, "/done_pulse"}, 64'(Done), 64'd0);
            chk({tag, "/ready_back"}, 64'(Ready), 64'd1);
            chk({tag, "/busy_off"}, 64'(Busy), 64'd0);
            chk({tag, "/busB_idle"}, ALUBusB, 64'd0);
            chk({tag, "/product_held"}, Product, a * b);
        end
    endtask

    task automatic start_mul(input logic [63:0] a, input logic [63:0] b, input string tag);
        chk({tag, "/ready_pre"}, 64'(Ready), 64'd1);
        Start = 1'b1;
        MulA  = a;
        MulB  = b;
        @(posedge CLK); #1;
        Start = 1'b0;
        MulA  = {$urandom, $urandom};
        MulB  = {$urandom, $urandom};
        run_body(a, b, tag);
    endtask

    initial begin
        logic [63:0] a1, b1, a2, b2;
        int ndone;
        Reset = 1'b1;
        Start = 1'b0;
        MulA  = '0;
        MulB  = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst/ready", 64'(Ready), 64'd1);
        chk("rst/busy", 64'(Busy), 64'd0);
        chk("rst/done", 64'(Done), 64'd0);
        chk("rst/product", Product, 64'd0);
        chk("rst/ctrl", 64'(ALUCtrl), 64'd0);
        chk("rst/busA", ALUBusA, 64'd0);
        Reset = 1'b0;
        @(posedge CLK); #1;

        start_mul(64'd3, 64'd5, "3x5");

        // reset while idle clears the held product
        Reset = 1'b1;
        #1;
        chk("idle_rst/product", Product, 64'd0);
        chk("idle_rst/ready", 64'(Ready), 64'd1);
        chk("idle_rst/busy", 64'(Busy), 64'd0);
        chk("idle_rst/ctrl", 64'(ALUCtrl), 64'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        @(posedge CLK); #1;

        start_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "ones_x2");
        start_mul(64'h8000_0000_0000_0000, 64'd2, "wrap");
        start_mul({$urandom, $urandom}, 64'd0, "b_zero");
        start_mul({$urandom, $urandom}, 64'd1, "b_one");
        start_mul({$urandom, $urandom}, 64'h8000_0000_0000_0001, "b_msb");

        for (int i = 0; i < 8; i++) begin
            a1 = {$urandom, $urandom};
            b1 = {$urandom, $urandom} >> $urandom_range(63, 0);
            start_mul(a1, b1, "rand");
        end

        // Start held through a run: operands changed mid-run take effect on re-accept
        a1 = {$urandom, $urandom};
        b1 = {$urandom, $urandom} >> $urandom_range(63, 0);
        a2 = {$urandom, $urandom};
        b2 = {$urandom, $urandom} >> $urandom_range(63, 0);
        Start = 1'b1;
        MulA  = a1;
        MulB  = b1;
        @(posedge CLK); #1;
        MulA = a2;
        MulB = b2;
        run_body(a1, b1, "held1");
        @(posedge CLK); #1;
        Start = 1'b0;
        run_body(a2, b2, "held2");

        // reset mid-run at cycle 30
        a1 = {$urandom, $urandom};
        b1 = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        Start = 1'b1;
        MulA  = a1;
        MulB  = b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (29) @(posedge CLK);
        #1;
        chk("midrun/busy_before", 64'(Busy), 64'd1);
        Reset = 1'b1;
        #1;
        chk("midrun/busy", 64'(Busy), 64'd0);
        chk("midrun/product", Product, 64'd0);
        chk("midrun/ready", 64'(Ready), 64'd1);
        chk("midrun/ctrl", 64'(ALUCtrl), 64'd0);
        chk("midrun/busA", ALUBusA, 64'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 70; i++) begin
            if (Done === 1'b1) ndone++;
            @(posedge CLK); #1;
        end
        chk("midrun/no_done", 64'(ndone), 64'd0);
        start_mul(64'd7, 64'd6, "7x6");
        chk("7x6/forty_two", Product, 64'd42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
